draw_engine: RTL and testbench
==============================

Name: draw_engine

Overview:
Datapath stage directly downstream of the game control FSM. It consumes the 5-bit draw command and rasterises the selected rectangle into the VGA adapter, one pixel per cycle. The rectangle is a brick, the paddle or the ball, drawn in colour or erased in black. It returns a combinational busy flag, which top level fans out to the FSM's populating_brickN, erasing/drawing_paddle, erasing/drawing_ball and removing_brickN inputs.

Parameters:
SCREEN_W, 160, visible width in pixels
SCREEN_H, 120, visible height in pixels
BRICK_X0, 4, x of brick column 0
BRICK_Y0, 10, y of brick row 0
BRICK_PITCH_X, 39, horizontal brick pitch
BRICK_PITCH_Y, 9, vertical brick pitch
BRICK_W, 36, brick width
BRICK_H, 6, brick height
PADDLE_Y, 110, paddle top row
PADDLE_W, 24, paddle width
PADDLE_H, 3, paddle height
BALL_SIZE, 2, ball side length

Ports:
clk  in  1  clock
resetn  in  1  synchronous, active-low reset
ld_draw  in  5  draw command from control FSM
paddle_x  in  8  current paddle left x
ball_x  in  8  current ball left x
ball_y  in  7  current ball top y
busy  out  1  command accepted and not yet complete (combinational)
vga_x  out  8  pixel x
vga_y  out  7  pixel y
vga_colour  out  3  pixel colour {R,G,B}
vga_plot  out  1  write strobe

Behaviour:
- Reset is resetn, synchronous, active-low, on clk. Reset is applied in any state, including mid-RUN.
- Values after reset:
  - state=IDLE, done_q=0, cmd_q=0, counters=0.
  - pad_old=0, ball_old_x=0, ball_old_y=0.
  - vga_plot=0, vga_x=0, vga_y=0, vga_colour=0.
- Command decode:
  - 0: idle.
  - 1-12: populate brick k. col=(k-1)%4, row=(k-1)/4. x0=BRICK_X0+col*PITCH_X, y0=BRICK_Y0+row*PITCH_Y. Colour by row: row0 3'b100, row1 3'b110, row2 3'b010.
  - 13: draw paddle at paddle_x, PADDLE_Y, colour 3'b111.
  - 14: erase paddle at pad_old, colour 3'b000.
  - 15: draw ball at ball_x, ball_y, colour 3'b111.
  - 16: erase ball at ball_old_x, ball_old_y, colour 3'b000.
  - 17-28: remove brick k-16, same geometry as populate, colour 3'b000.
  - 29-31: no-op. busy=0, no plot.
- valid = ld_draw in 1..28.
- busy = valid && !(done_q && ld_draw==cmd_q). busy is combinational so the FSM sees it in the same cycle it presents a command.
- FSM IDLE:
  - If valid and the command is not the completed one, latch cmd_q, x0, y0, w, h and colour, clear done_q and counters, and go to RUN.
  - On accepting 13, pad_old<=paddle_x.
  - On accepting 15, ball_old_x<=ball_x and ball_old_y<=ball_y.
- FSM RUN:
  - Row-major scan: cx 0..w-1 inner, cy 0..h-1 outer.
  - vga_x=x0+cx, vga_y=y0+cy, vga_colour=colour_q.
  - vga_plot=1 except when clipped.
  - After the pixel (w-1,h-1): done_q<=1 and go to IDLE.
- Latency: command first seen at cycle t. First pixel at t+1. Last pixel at t+w*h. busy low at t+w*h+1.
- ld_draw changing while in RUN is ignored; the FSM holds ld_draw stable while busy=1.
- done_q clears automatically on any ld_draw != cmd_q: the next valid command is accepted in that cycle. The same code re-presented after a different code is redrawn.
- Clipping: sums are computed at 9b (x) and 8b (y). A pixel with x>=SCREEN_W or y>=SCREEN_H has vga_plot=0, but still consumes its cycle so latency is fixed.
- Outside RUN, vga_plot=0 and vga_x/vga_y/vga_colour hold their last values.

Decomposition:
- Shared package game_pkg holds:
  - Command code localparams (CMD_POP_BASE=1, CMD_DRAW_PADDLE=13, CMD_ERASE_PADDLE=14, CMD_DRAW_BALL=15, CMD_ERASE_BALL=16, CMD_REMOVE_BASE=17). The control FSM reuses these.
  - Colour constants.
  - Screen size.
- One sub-module, brick_geom: combinational brick index (1-12) -> x0, y0, row colour.
- The raster counter stays in the top level.

Test Plan:
- Reset, then ld_draw=1 at cycle t:
  - 216 plots covering x 4..39, y 10..15, colour 3'b100.
  - busy=1 for cycles t..t+216, 0 at t+217.
- ld_draw=7: plots x 82..117, y 19..24, colour 3'b110. Then ld_draw=23 (remove brick 7): same 216 pixels, colour 3'b000.
- ld_draw=13 with paddle_x=50: 72 plots at x 50..73, y 110..112, white. Then paddle_x=60, ld_draw=14: erase still at x 50..73, black.
- Back-to-back 1 then 2, with the FSM switching command the cycle after busy falls:
  - busy low for exactly 1 cycle.
  - Brick 2 starts at x=43, no pixel lost or duplicated.
- ld_draw=15 with ball_x=159, ball_y=119: 4 cycles of RUN, vga_plot=1 only for (159,119). busy low on the 5th cycle.
- Reset asserted at the 10th pixel of brick 1: next cycle plot=0 and busy evaluated fresh. With ld_draw=1 held, the redraw restarts at (4,10).
- ld_draw=30: busy=0, vga_plot never asserted.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared command codes, colours and screen geometry for the game datapath
package game_pkg;

  localparam int SCREEN_W      = 160;
  localparam int SCREEN_H      = 120;

  localparam int BRICK_X0      = 4;
  localparam int BRICK_Y0      = 10;
  localparam int BRICK_PITCH_X = 39;
  localparam int BRICK_PITCH_Y = 9;
  localparam int BRICK_W       = 36;
  localparam int BRICK_H       = 6;

  localparam int PADDLE_Y      = 110;
  localparam int PADDLE_W      = 24;
  localparam int PADDLE_H      = 3;
  localparam int BALL_SIZE     = 2;

  localparam int CMD_POP_BASE     = 1;
  localparam int CMD_DRAW_PADDLE  = 13;
  localparam int CMD_ERASE_PADDLE = 14;
  localparam int CMD_DRAW_BALL    = 15;
  localparam int CMD_ERASE_BALL   = 16;
  localparam int CMD_REMOVE_BASE  = 17;
  localparam int CMD_LAST         = 28;

  localparam logic [2:0] COL_BLACK  = 3'b000;
  localparam logic [2:0] COL_RED    = 3'b100;
  localparam logic [2:0] COL_YELLOW = 3'b110;
  localparam logic [2:0] COL_GREEN  = 3'b010;
  localparam logic [2:0] COL_WHITE  = 3'b111;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } draw_state_e;

  // Codes 1..28 select a rectangle; 0 and 29..31 are no-ops.
  function automatic logic cmd_valid(input logic [4:0] c);
    return (c >= 5'(CMD_POP_BASE)) && (c <= 5'(CMD_LAST));
  endfunction

endpackage

// File: rtl/draw_engine_if.sv
// rtl/draw_engine_if.sv - command handshake and VGA pixel bus of the draw engine
interface draw_engine_if;
  logic [4:0] ld_draw;
  logic [7:0] paddle_x;
  logic [7:0] ball_x;
  logic [6:0] ball_y;
  logic       busy;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  modport master (
    output ld_draw, paddle_x, ball_x, ball_y,
    input  busy, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  ld_draw, paddle_x, ball_x, ball_y,
    output busy, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/brick_geom.sv
// rtl/brick_geom.sv - brick index (1..12) to top-left corner and row colour
module brick_geom
  import game_pkg::*;
(
  input  logic [3:0] idx_i,
  output logic [7:0] x0_o,
  output logic [6:0] y0_o,
  output logic [2:0] colour_o
);

  logic [3:0] k;
  logic [1:0] col;
  logic [1:0] row;

  assign k   = idx_i - 4'd1;
  assign col = k[1:0];
  assign row = k[3:2];

  // Four bricks per row; the row also picks the brick colour.
  always_comb begin
    x0_o = 8'(BRICK_X0 + BRICK_PITCH_X * int'(col));
    y0_o = 7'(BRICK_Y0 + BRICK_PITCH_Y * int'(row));
    case (row)
      2'd0:    colour_o = COL_RED;
      2'd1:    colour_o = COL_YELLOW;
      2'd2:    colour_o = COL_GREEN;
      default: colour_o = COL_BLACK;
    endcase
  end

endmodule

// File: rtl/draw_engine.sv
// rtl/draw_engine.sv - rasterises one brick/paddle/ball rectangle per command, one pixel per cycle
module draw_engine
  import game_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  draw_engine_if.slave bus
);

  draw_state_e state_q, state_d;
  logic       done_q, done_d;
  logic [4:0] cmd_q, cmd_d;
  logic [7:0] x0_q, x0_d;
  logic [6:0] y0_q, y0_d;
  logic [5:0] w_q, w_d;
  logic [2:0] h_q, h_d;
  logic [2:0] colour_q, colour_d;
  logic [5:0] cx_q, cx_d;
  logic [2:0] cy_q, cy_d;
  logic [7:0] pad_old_q, pad_old_d;
  logic [7:0] ball_old_x_q, ball_old_x_d;
  logic [6:0] ball_old_y_q, ball_old_y_d;
  logic [7:0] hold_x_q, hold_x_d;
  logic [6:0] hold_y_q, hold_y_d;
  logic [2:0] hold_col_q, hold_col_d;

  logic [7:0] geom_x0;
  logic [6:0] geom_y0;
  logic [2:0] geom_col;
  logic [8:0] x_sum;
  logic [7:0] y_sum;
  logic       running;
  logic       clipped;

  // Populate codes 1..12 and remove codes 17..28 share the low four bits
  // of the brick index, so the low nibble of ld_draw feeds the geometry.
  brick_geom u_brick_geom (
    .idx_i    (bus.ld_draw[3:0]),
    .x0_o     (geom_x0),
    .y0_o     (geom_y0),
    .colour_o (geom_col)
  );

  assign running = (state_q == ST_RUN);
  assign x_sum   = {1'b0, x0_q} + {3'b000, cx_q};
  assign y_sum   = {1'b0, y0_q} + {5'b00000, cy_q};
  assign clipped = (x_sum >= 9'(SCREEN_W)) || (y_sum >= 8'(SCREEN_H));

  assign bus.busy       = cmd_valid(bus.ld_draw) && !(done_q && (bus.ld_draw == cmd_q));
  assign bus.vga_plot   = running && !clipped;
  assign bus.vga_x      = running ? x_sum[7:0] : hold_x_q;
  assign bus.vga_y      = running ? y_sum[6:0] : hold_y_q;
  assign bus.vga_colour = running ? colour_q   : hold_col_q;

  // State, geometry latch and raster counters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      done_q       <= 1'b0;
      cmd_q        <= '0;
      x0_q         <= '0;
      y0_q         <= '0;
      w_q          <= '0;
      h_q          <= '0;
      colour_q     <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      pad_old_q    <= '0;
      ball_old_x_q <= '0;
      ball_old_y_q <= '0;
      hold_x_q     <= '0;
      hold_y_q     <= '0;
      hold_col_q   <= '0;
    end else begin
      state_q      <= state_d;
      done_q       <= done_d;
      cmd_q        <= cmd_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      w_q          <= w_d;
      h_q          <= h_d;
      colour_q     <= colour_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      pad_old_q    <= pad_old_d;
      ball_old_x_q <= ball_old_x_d;
      ball_old_y_q <= ball_old_y_d;
      hold_x_q     <= hold_x_d;
      hold_y_q     <= hold_y_d;
      hold_col_q   <= hold_col_d;
    end
  end

  // Accept a command in IDLE, then scan the rectangle row-major in RUN.
  always_comb begin
    state_d      = state_q;
    done_d       = done_q;
    cmd_d        = cmd_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    w_d          = w_q;
    h_d          = h_q;
    colour_d     = colour_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    pad_old_d    = pad_old_q;
    ball_old_x_d = ball_old_x_q;
    ball_old_y_d = ball_old_y_q;
    hold_x_d     = hold_x_q;
    hold_y_d     = hold_y_q;
    hold_col_d   = hold_col_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.busy) begin
          state_d = ST_RUN;
          done_d  = 1'b0;
          cmd_d   = bus.ld_draw;
          cx_d    = '0;
          cy_d    = '0;
          case (bus.ld_draw)
            5'(CMD_DRAW_PADDLE): begin
              x0_d      = bus.paddle_x;
              y0_d      = 7'(PADDLE_Y);
              w_d       = 6'(PADDLE_W);
              h_d       = 3'(PADDLE_H);
              colour_d  = COL_WHITE;
              pad_old_d = bus.paddle_x;
            end
            5'(CMD_ERASE_PADDLE): begin
              x0_d     = pad_old_q;
              y0_d     = 7'(PADDLE_Y);
              w_d      = 6'(PADDLE_W);
              h_d      = 3'(PADDLE_H);
              colour_d = COL_BLACK;
            end
            5'(CMD_DRAW_BALL): begin
              x0_d         = bus.ball_x;
              y0_d         = bus.ball_y;
              w_d          = 6'(BALL_SIZE);
              h_d          = 3'(BALL_SIZE);
              colour_d     = COL_WHITE;
              ball_old_x_d = bus.ball_x;
              ball_old_y_d = bus.ball_y;
            end
            5'(CMD_ERASE_BALL): begin
              x0_d     = ball_old_x_q;
              y0_d     = ball_old_y_q;
              w_d      = 6'(BALL_SIZE);
              h_d      = 3'(BALL_SIZE);
              colour_d = COL_BLACK;
            end
            default: begin
              x0_d     = geom_x0;
              y0_d     = geom_y0;
              w_d      = 6'(BRICK_W);
              h_d      = 3'(BRICK_H);
              colour_d = (bus.ld_draw < 5'(CMD_REMOVE_BASE)) ? geom_col : COL_BLACK;
            end
          endcase
        end else if (done_q && (bus.ld_draw != cmd_q)) begin
          done_d = 1'b0;
        end
      end

      ST_RUN: begin
        hold_x_d   = x_sum[7:0];
        hold_y_d   = y_sum[6:0];
        hold_col_d = colour_q;
        if (cx_q == w_q - 6'd1) begin
          cx_d = '0;
          if (cy_q == h_q - 3'd1) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cy_d = cy_q + 3'd1;
          end
        end else begin
          cx_d = cx_q + 6'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_draw_engine.sv
// tb/tb_draw_engine.sv - self-checking bench for draw_engine against a pixel-list model
module tb_draw_engine;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  draw_engine_if bus ();

  draw_engine dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    int         x;
    int         y;
    logic [2:0] c;
  } pix_t;

  int checks = 0;
  int failures = 0;

  pix_t pend[$];
  logic mdone = 1'b0;
  int   mcmd = 0, mpad = 0, mbx = 0, mby = 0;
  int   lastx = 0, lasty = 0, lastc = 0;
  logic cmp_en = 1'b0;

  int plot_cnt, minx, maxx, miny, maxy, last_pc, first_x, first_y;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_stats();
    plot_cnt = 0; minx = 999; maxx = -1; miny = 999; maxy = -1;
    last_pc = -1; first_x = -1; first_y = -1;
  endtask

  // Build the full list of pixels one command must produce, row-major.
  task automatic build(input int cmd);
    int x0, y0, w, h, k, col, row;
    logic [2:0] c;
    x0 = 0; y0 = 0; w = 0; h = 0; c = 3'b000;
    if ((cmd >= 1 && cmd <= 12) || (cmd >= 17 && cmd <= 28)) begin
      k   = (cmd <= 12) ? cmd : cmd - 16;
      col = (k - 1) % 4;
      row = (k - 1) / 4;
      x0  = 4 + 39 * col;
      y0  = 10 + 9 * row;
      w   = 36; h = 6;
      if (cmd <= 12) c = (row == 0) ? 3'b100 : (row == 1) ? 3'b110 : 3'b010;
    end else if (cmd == 13) begin
      mpad = int'(bus.paddle_x);
      x0 = mpad; y0 = 110; w = 24; h = 3; c = 3'b111;
    end else if (cmd == 14) begin
      x0 = mpad; y0 = 110; w = 24; h = 3;
    end else if (cmd == 15) begin
      mbx = int'(bus.ball_x); mby = int'(bus.ball_y);
      x0 = mbx; y0 = mby; w = 2; h = 2; c = 3'b111;
    end else if (cmd == 16) begin
      x0 = mbx; y0 = mby; w = 2; h = 2;
    end
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++) begin
        pix_t p;
        p.x = x0 + xx; p.y = y0 + yy; p.c = c;
        pend.push_back(p);
      end
  endtask

  // Per-cycle compare against the model, then advance the model one clock.
  always @(negedge clk) begin
    int   ld;
    logic ebusy, eplot;
    int   ex, ey, ec;
    if (cmp_en) begin
      ld    = int'(bus.ld_draw);
      ebusy = (ld >= 1 && ld <= 28) && !(mdone && ld == mcmd);
      if (pend.size() > 0) begin
        eplot = (pend[0].x < 160) && (pend[0].y < 120);
        ex = pend[0].x % 256; ey = pend[0].y % 128; ec = int'(pend[0].c);
      end else begin
        eplot = 1'b0; ex = lastx; ey = lasty; ec = lastc;
      end
      chk("busy", int'(bus.busy), int'(ebusy));
      chk("vga_plot", int'(bus.vga_plot), int'(eplot));
      chk("vga_x", int'(bus.vga_x), ex);
      chk("vga_y", int'(bus.vga_y), ey);
      chk("vga_colour", int'(bus.vga_colour), ec);

      if (bus.vga_plot) begin
        if (plot_cnt == 0) begin first_x = int'(bus.vga_x); first_y = int'(bus.vga_y); end
        plot_cnt++;
        if (int'(bus.vga_x) < minx) minx = int'(bus.vga_x);
        if (int'(bus.vga_x) > maxx) maxx = int'(bus.vga_x);
        if (int'(bus.vga_y) < miny) miny = int'(bus.vga_y);
        if (int'(bus.vga_y) > maxy) maxy = int'(bus.vga_y);
        last_pc = int'(bus.vga_colour);
      end

      if (!resetn) begin
        pend.delete();
        mdone = 1'b0; mcmd = 0; mpad = 0; mbx = 0; mby = 0;
        lastx = 0; lasty = 0; lastc = 0;
      end else if (pend.size() > 0) begin
        lastx = ex; lasty = ey; lastc = ec;
        void'(pend.pop_front());
        if (pend.size() == 0) mdone = 1'b1;
      end else if (ebusy) begin
        mcmd  = ld;
        mdone = 1'b0;
        build(ld);
      end else if (mdone && ld != mcmd) begin
        mdone = 1'b0;
      end
    end
  end

  task automatic drive(input int c);
    @(posedge clk); #1;
    bus.ld_draw = 5'(c);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    forever begin
      @(negedge clk); #1;
      if (!bus.busy) break;
      n++;
      if (n > 400) begin
        chk("busy_timeout", n, -1);
        break;
      end
    end
  endtask

  initial begin
    int n;
    bus.ld_draw = '0; bus.paddle_x = '0; bus.ball_x = '0; bus.ball_y = '0;
    clear_stats();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 cmp_en = 1'b1;
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk); #1;
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_plot", int'(bus.vga_plot), 0);
    chk("reset_x", int'(bus.vga_x), 0);
    chk("reset_y", int'(bus.vga_y), 0);
    chk("reset_colour", int'(bus.vga_colour), 0);

    // Brick 1
    drive(1); clear_stats();
    wait_idle(n);
    chk("b1_busy_cycles", n, 217);
    chk("b1_plots", plot_cnt, 216);
    chk("b1_minx", minx, 4);   chk("b1_maxx", maxx, 39);
    chk("b1_miny", miny, 10);  chk("b1_maxy", maxy, 15);
    chk("b1_colour", last_pc, 4);

    // Back-to-back brick 2: busy low only for the one cycle just observed
    drive(2); clear_stats();
    @(negedge clk); #1;
    chk("b2_busy_again", int'(bus.busy), 1);
    wait_idle(n);
    chk("b2_plots", plot_cnt, 216);
    chk("b2_first_x", first_x, 43);
    chk("b2_maxx", maxx, 78);

    // Brick 7 populate and remove
    drive(7); clear_stats(); wait_idle(n);
    chk("b7_minx", minx, 82);  chk("b7_maxx", maxx, 117);
    chk("b7_miny", miny, 19);  chk("b7_maxy", maxy, 24);
    chk("b7_colour", last_pc, 6);
    drive(23); clear_stats(); wait_idle(n);
    chk("r7_plots", plot_cnt, 216);
    chk("r7_minx", minx, 82);
    chk("r7_colour", last_pc, 0);

    // Paddle draw, then erase after the paddle moved
    bus.paddle_x = 8'd50;
    drive(13); clear_stats(); wait_idle(n);
    chk("pd_plots", plot_cnt, 72);
    chk("pd_minx", minx, 50);  chk("pd_maxx", maxx, 73);
    chk("pd_miny", miny, 110); chk("pd_maxy", maxy, 112);
    chk("pd_colour", last_pc, 7);
    bus.paddle_x = 8'd60;
    drive(14); clear_stats(); wait_idle(n);
    chk("pe_minx", minx, 50);  chk("pe_maxx", maxx, 73);
    chk("pe_colour", last_pc, 0);

    // Ball in the bottom-right corner: three of four pixels clipped
    bus.ball_x = 8'd159; bus.ball_y = 7'd119;
    drive(15); clear_stats(); wait_idle(n);
    chk("ball_busy_cycles", n, 5);
    chk("ball_plots", plot_cnt, 1);
    chk("ball_x", first_x, 159);
    chk("ball_y", first_y, 119);

    // Same code re-presented after a different code is redrawn
    drive(0);
    drive(15); clear_stats(); wait_idle(n);
    chk("ball_redraw_cycles", n, 5);

    // No-op code
    drive(30); clear_stats();
    repeat (20) @(negedge clk);
    #1 chk("noop_plots", plot_cnt, 0);

    // Reset during the 10th pixel of brick 1
    drive(1); clear_stats();
    n = 0;
    while (plot_cnt < 9 && n < 400) begin @(negedge clk); #1 n++; end
    chk("pre_reset_plots", plot_cnt, 9);
    @(posedge clk); #1 resetn = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk); #1;
    chk("post_reset_plot", int'(bus.vga_plot), 0);
    chk("post_reset_busy", int'(bus.busy), 1);
    clear_stats();
    wait_idle(n);
    chk("redraw_first_x", first_x, 4);
    chk("redraw_first_y", first_y, 10);
    chk("redraw_plots", plot_cnt, 216);

    // Randomised commands and positions, checked by the per-cycle model
    for (int i = 0; i < 40; i++) begin
      bus.paddle_x = 8'($urandom_range(0, 255));
      bus.ball_x   = 8'($urandom_range(0, 255));
      bus.ball_y   = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 1) == 1) drive(0);
      drive(int'($urandom_range(0, 31)));
      wait_idle(n);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
